// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: op encodings, op legality,
// decoder mapping and the per-stage mux-level split.
package shift_pkg;

  localparam logic [2:0] SH_SLL = 3'b000;
  localparam logic [2:0] SH_SRL = 3'b001;
  localparam logic [2:0] SH_SRA = 3'b010;
  localparam logic [2:0] SH_ROL = 3'b011;
  localparam logic [2:0] SH_ROR = 3'b100;

  // Encodings above SH_ROR are reserved and flagged as errors.
  function automatic logic sh_legal(input logic [2:0] op);
    return (op <= SH_ROR);
  endfunction

  // Maps the instruction func3/func7 fields onto an SH_* op (base shifts plus
  // the rotate extension). Anything unrecognised decodes to an illegal op.
  function automatic logic [2:0] sh_decode(input logic [2:0] func3, input logic [6:0] func7);
    logic [2:0] op;
    op = 3'b111;
    case (func3)
      3'b001: begin
        if (func7 == 7'b0000000)      op = SH_SLL;
        else if (func7 == 7'b0110000) op = SH_ROL;
      end
      3'b101: begin
        if (func7 == 7'b0000000)      op = SH_SRL;
        else if (func7 == 7'b0100000) op = SH_SRA;
        else if (func7 == 7'b0110000) op = SH_ROR;
      end
      default: op = 3'b111;
    endcase
    return op;
  endfunction

  // First mux level owned by stage k. Levels are spread front-loaded:
  // each stage takes ceil(remaining levels / remaining stages).
  function automatic int level_lo(input int k, input int nlev, input int nst);
    int lo;
    lo = 0;
    for (int i = 0; i < k; i++) begin
      lo = lo + (nlev - lo + (nst - i) - 1) / (nst - i);
    end
    return lo;
  endfunction

endpackage

// File: rtl/shift_levels.sv
// Combinational slice of the log-shifter: applies mux levels LO..HI-1.
// Level j moves the data by 2^j when shamt[j] is set.
module shift_levels
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int LO   = 0,
  parameter int HI   = 1
) (
  input  logic [XLEN-1:0]         data_in,
  input  logic [$clog2(XLEN)-1:0] shamt,
  input  logic [2:0]              op,
  input  logic                    fill,
  output logic [XLEN-1:0]         data_out
);

  logic [XLEN-1:0] d;

  // Only a subset of shamt bits belongs to this slice.
  logic unused_shamt;
  assign unused_shamt = ^shamt;

  // Cascade this slice's mux levels; illegal ops pass the data through.
  always_comb begin
    d = data_in;
    for (int j = LO; j < HI; j++) begin
      if (shamt[j]) begin
        case (op)
          SH_SLL:  d = d << (1 << j);
          SH_SRL:  d = d >> (1 << j);
          SH_SRA:  d = (d >> (1 << j)) | ({XLEN{fill}} << (XLEN - (1 << j)));
          SH_ROL:  d = (d << (1 << j)) | (d >> (XLEN - (1 << j)));
          SH_ROR:  d = (d >> (1 << j)) | (d << (XLEN - (1 << j)));
          default: d = d;
        endcase
      end
    end
    data_out = d;
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROL/ROR shifter with elastic valid/ready stages.
// Each stage runs a share of the mux levels and then registers the op.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int TAGW   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  input  logic [TAGW-1:0]         in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAGW-1:0]         out_tag,
  output logic                    out_err
);

  localparam int LVLS = $clog2(XLEN);

  // Index 0 is the request port, index k+1 the register of stage k.
  logic [STAGES:0] st_valid;
  logic [STAGES:0] st_fill;
  logic [STAGES:0] st_err;
  logic [XLEN-1:0] st_data  [STAGES+1];
  logic [LVLS-1:0] st_shamt [STAGES+1];
  logic [2:0]      st_op    [STAGES+1];
  logic [TAGW-1:0] st_tag   [STAGES+1];
  logic [STAGES:0] advance;

  assign st_valid[0] = in_valid;
  assign st_data[0]  = in_data;
  assign st_shamt[0] = in_shamt;
  assign st_op[0]    = in_op;
  assign st_tag[0]   = in_tag;
  assign st_fill[0]  = in_data[XLEN-1];
  assign st_err[0]   = ~sh_legal(in_op);

  // A stage may load when it is empty or its successor is moving.
  always_comb begin
    advance         = '0;
    advance[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance[k] = ~st_valid[k+1] | advance[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = level_lo(gi, LVLS, STAGES);
      localparam int HI = level_lo(gi + 1, LVLS, STAGES);

      logic [XLEN-1:0] lvl_data;
      logic            valid_reg;
      logic [XLEN-1:0] data_reg;
      logic [LVLS-1:0] shamt_reg;
      logic [2:0]      op_reg;
      logic            fill_reg;
      logic [TAGW-1:0] tag_reg;
      logic            err_reg;

      shift_levels #(
        .XLEN (XLEN),
        .LO   (LO),
        .HI   (HI)
      ) u_levels (
        .data_in  (st_data[gi]),
        .shamt    (st_shamt[gi]),
        .op       (st_op[gi]),
        .fill     (st_fill[gi]),
        .data_out (lvl_data)
      );

      // Stage register: reset flushes in-flight ops; payload only loads with a valid op.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          shamt_reg <= '0;
          op_reg    <= '0;
          fill_reg  <= 1'b0;
          tag_reg   <= '0;
          err_reg   <= 1'b0;
        end else if (advance[gi]) begin
          valid_reg <= st_valid[gi];
          if (st_valid[gi]) begin
            data_reg  <= lvl_data;
            shamt_reg <= st_shamt[gi];
            op_reg    <= st_op[gi];
            fill_reg  <= st_fill[gi];
            tag_reg   <= st_tag[gi];
            err_reg   <= st_err[gi];
          end
        end
      end

      assign st_valid[gi+1] = valid_reg;
      assign st_data[gi+1]  = data_reg;
      assign st_shamt[gi+1] = shamt_reg;
      assign st_op[gi+1]    = op_reg;
      assign st_fill[gi+1]  = fill_reg;
      assign st_tag[gi+1]   = tag_reg;
      assign st_err[gi+1]   = err_reg;
    end
  endgenerate

  // Control fields of the final stage have no consumer beyond the pipe.
  logic unused_tail;
  assign unused_tail = ^{st_shamt[STAGES], st_op[STAGES], st_fill[STAGES]};

  // Neither side may complete a transfer during a reset cycle.
  assign in_ready  = advance[0] & ~rst;
  assign out_valid = st_valid[STAGES] & ~rst;
  assign out_data  = st_data[STAGES];
  assign out_tag   = st_tag[STAGES];
  assign out_err   = st_err[STAGES];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: 32-bit/2-stage DUT plus six 64-bit
// instances with STAGES=1..6 sharing one random stimulus stream.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [2:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  logic        w_in_valid = 1'b0;
  logic [5:0]  w_in_ready;
  logic [63:0] w_in_data = '0;
  logic [5:0]  w_in_shamt = '0;
  logic [2:0]  w_in_op = '0;
  logic [4:0]  w_in_tag = '0;
  logic [5:0]  w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [63:0] w_out_data [6];
  logic [4:0]  w_out_tag [6];
  logic [5:0]  w_out_err;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  bit          obs_acc, obs_prod, obs_have;
  exp_t        obs_exp;
  logic [31:0] obs_data;
  logic [4:0]  obs_tag;
  logic        obs_err, obs_in_ready, obs_out_valid;

  always #5 clk = ~clk;

  shift_unit_pipe #(.XLEN(32), .STAGES(2), .TAGW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_wide
      shift_unit_pipe #(.XLEN(64), .STAGES(gi + 1), .TAGW(5)) u_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready[gi]),
        .in_data   (w_in_data),
        .in_shamt  (w_in_shamt),
        .in_op     (w_in_op),
        .in_tag    (w_in_tag),
        .out_valid (w_out_valid[gi]),
        .out_ready (w_out_ready),
        .out_data  (w_out_data[gi]),
        .out_tag   (w_out_tag[gi]),
        .out_err   (w_out_err[gi])
      );
    end
  endgenerate

  // Reference: bitwise shift/rotate on a masked 64-bit container.
  function automatic logic [63:0] ref_shift(input int xlen, input logic [2:0] op,
                                            input logic [63:0] d_in, input int sh);
    logic [63:0] mask, d, r;
    mask = (xlen == 64) ? {64{1'b1}} : ((64'd1 << xlen) - 64'd1);
    d = d_in & mask;
    case (op)
      3'b000: r = (d << sh) & mask;
      3'b001: r = d >> sh;
      3'b010: begin
        r = d >> sh;
        if (d[xlen-1]) r = r | (mask & ~(mask >> sh));
      end
      3'b011: r = (sh == 0) ? d : (((d << sh) | (d >> (xlen - sh))) & mask);
      3'b100: r = (sh == 0) ? d : (((d >> sh) | (d << (xlen - sh))) & mask);
      default: r = d;
    endcase
    return r;
  endfunction

  // One cycle: observe handshakes at negedge, update scoreboard, return after posedge.
  task automatic step();
    logic [63:0] r;
    exp_t e;
    @(negedge clk);
    obs_acc       = in_valid && in_ready;
    obs_prod      = out_valid && out_ready;
    obs_data      = out_data;
    obs_tag       = out_tag;
    obs_err       = out_err;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_have      = 1'b0;
    if (obs_prod && sb.size() > 0) begin
      obs_exp  = sb.pop_front();
      obs_have = 1'b1;
    end
    if (obs_acc) begin
      r   = ref_shift(32, in_op, {32'd0, in_data}, int'(in_shamt));
      e.d = r[31:0];
      e.t = in_tag;
      e.e = (in_op > 3'd4);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(input int tag, input int max_op);
    in_data  = $urandom;
    in_shamt = 5'($urandom_range(0, 31));
    in_op    = 3'($urandom_range(0, max_op));
    in_tag   = 5'(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    checks++;
    if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", obs_out_valid, obs_in_ready);
    end
    checks++;
    if (obs_data !== 32'd0 || obs_tag !== 5'd0 || obs_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: data=%h tag=%0d err=%b expected 0", obs_data, obs_tag, obs_err);
    end
  endtask

  task automatic test_single_ops();
    logic [2:0]  t_op  [6] = '{SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR, SH_SRA};
    logic [31:0] t_din [6] = '{32'h00000001, 32'hF0000000, 32'hF0000000,
                               32'h80000001, 32'h80000001, 32'h7FFFFFFF};
    logic [4:0]  t_sh  [6] = '{5'd4, 5'd4, 5'd4, 5'd1, 5'd31, 5'd31};
    logic [31:0] t_exp [6] = '{32'h00000010, 32'h0F000000, 32'hFF000000,
                               32'h00000003, 32'h00000003, 32'h00000000};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int  lat;
      bit  got;
      in_valid = 1'b1; in_op = t_op[i]; in_data = t_din[i]; in_shamt = t_sh[i]; in_tag = 5'(i);
      step();
      in_valid = 1'b0;
      checks++;
      if (!obs_acc) begin
        errors++;
        $display("FAIL single_accept[%0d]: in_ready=%b expected 1", i, obs_in_ready);
      end
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
        step();
        lat++;
        if (obs_prod) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL single_timeout[%0d]: no result within 10 cycles", i);
      end else begin
        checks++;
        if (obs_data !== t_exp[i] || obs_err !== 1'b0) begin
          errors++;
          $display("FAIL single_data[%0d]: got %h err=%b expected %h err=0", i, obs_data, obs_err, t_exp[i]);
        end
        checks++;
        if (lat != 2) begin
          errors++;
          $display("FAIL single_latency[%0d]: got %0d expected 2", i, lat);
        end
        checks++;
        if (!obs_have || obs_exp.d !== obs_data || obs_exp.t !== obs_tag) begin
          errors++;
          $display("FAIL single_sb[%0d]: got %h/%0d expected %h/%0d", i, obs_data, obs_tag, obs_exp.d, obs_exp.t);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1;
    bit drop = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      if (sent < 16) begin
        in_valid = 1'b1;
        rand_op(sent, 4);
      end else in_valid = 1'b0;
      step();
      if (sent < 16 && !obs_in_ready) drop = 1'b1;
      if (obs_acc) sent++;
      if (obs_prod) begin
        if (first < 0) first = cyc;
        last = cyc;
        checks++;
        if (!obs_have || obs_data !== obs_exp.d || obs_tag !== obs_exp.t || obs_err !== obs_exp.e) begin
          errors++;
          $display("FAIL b2b_data[%0d]: got %h/%0d/%b expected %h/%0d/%b", got, obs_data, obs_tag, obs_err,
                   obs_exp.d, obs_exp.t, obs_exp.e);
        end
        checks++;
        if (obs_tag !== 5'(got)) begin
          errors++;
          $display("FAIL b2b_order: got tag %0d expected %0d", obs_tag, got);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", got); end
    checks++;
    if (drop) begin errors++; $display("FAIL b2b_in_ready: got dropped expected always 1"); end
    checks++;
    if (last - first != 15) begin
      errors++;
      $display("FAIL b2b_consecutive: got span %0d expected 15", last - first);
    end
  endtask

  task automatic test_stall();
    int i = 0, got = 0;
    bit new_op = 1'b1;
    logic [31:0] snap_d;
    logic [4:0]  snap_t;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (new_op) rand_op(i, 4);
      in_valid = 1'b1;
      step();
      new_op = obs_acc;
      if (obs_acc) i++;
      if (!obs_in_ready) break;
    end
    checks++;
    if (i != 2 || obs_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_fill: got %0d ops out_valid=%b expected 2 ops out_valid=1", i, obs_out_valid);
    end
    snap_d = obs_data;
    snap_t = obs_tag;
    repeat (5) begin
      step();
      checks++;
      if (obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1 || obs_data !== snap_d || obs_tag !== snap_t) begin
        errors++;
        $display("FAIL stall_hold: in_ready=%b out_valid=%b data=%h tag=%0d expected 0/1/%h/%0d",
                 obs_in_ready, obs_out_valid, obs_data, obs_tag, snap_d, snap_t);
      end
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (i < 6) begin
        if (new_op) rand_op(i, 4);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      step();
      new_op = obs_acc;
      if (obs_acc) i++;
      if (obs_prod) begin
        checks++;
        if (!obs_have || obs_data !== obs_exp.d || obs_tag !== 5'(got)) begin
          errors++;
          $display("FAIL stall_release[%0d]: got %h/%0d expected %h/%0d", got, obs_data, obs_tag, obs_exp.d, got);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d results, %0d pending expected 6, 0", got, sb.size());
    end
  endtask

  task automatic test_illegal();
    logic [2:0] t_op  [5] = '{SH_SLL, 3'b111, SH_SRL, 3'b101, 3'b110};
    bit         t_ill [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int sent = 0, got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      if (sent < 5) begin
        in_valid = 1'b1; in_op = t_op[sent]; in_data = 32'h12345678; in_shamt = 5'd4; in_tag = 5'(sent + 8);
      end else in_valid = 1'b0;
      step();
      if (obs_acc) sent++;
      if (obs_prod) begin
        checks++;
        if (obs_tag !== 5'(got + 8)) begin
          errors++;
          $display("FAIL illegal_order: got tag %0d expected %0d", obs_tag, got + 8);
        end
        checks++;
        if (t_ill[got]) begin
          if (obs_data !== 32'h12345678 || obs_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_pass[%0d]: got %h err=%b expected 12345678 err=1", got, obs_data, obs_err);
          end
        end else if (!obs_have || obs_data !== obs_exp.d || obs_err !== 1'b0) begin
          errors++;
          $display("FAIL illegal_neighbour[%0d]: got %h err=%b expected %h err=0", got, obs_data, obs_err, obs_exp.d);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 5) begin errors++; $display("FAIL illegal_count: got %0d expected 5", got); end
  endtask

  task automatic test_reset_flush();
    int prods = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; rand_op(20 + i, 4);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs_prod) begin errors++; $display("FAIL flush_rst_cycle: got out transfer expected none"); end
    sb.delete();
    step();
    checks++;
    if (obs_out_valid !== 1'b0 || obs_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: out_valid=%b in_ready=%b expected 0/1", obs_out_valid, obs_in_ready);
    end
    in_valid = 1'b1; rand_op(31, 4);
    step();
    in_valid = 1'b0;
    repeat (8) begin
      step();
      if (obs_prod) begin
        prods++;
        checks++;
        if (obs_tag !== 5'd31 || !obs_have || obs_data !== obs_exp.d) begin
          errors++;
          $display("FAIL flush_ghost: got tag %0d data %h expected tag 31", obs_tag, obs_data);
        end
      end
    end
    checks++;
    if (prods != 1) begin errors++; $display("FAIL flush_count: got %0d results expected 1", prods); end
  endtask

  task automatic test_wide();
    localparam int N = 32;
    logic [63:0] exp_wd [N];
    logic        exp_we [N];
    int          w_idx [6] = '{0, 0, 0, 0, 0, 0};
    int          w_first [6] = '{-1, -1, -1, -1, -1, -1};
    bit          ready_bad = 1'b0;
    w_out_ready = 1'b1;
    for (int cyc = 0; cyc < N + 12; cyc++) begin
      if (cyc < N) begin
        w_in_valid = 1'b1;
        w_in_data  = {$urandom, $urandom};
        w_in_shamt = 6'($urandom_range(0, 63));
        w_in_op    = 3'($urandom_range(0, 7));
        w_in_tag   = 5'(cyc);
        exp_wd[cyc] = ref_shift(64, w_in_op, w_in_data, int'(w_in_shamt));
        exp_we[cyc] = (w_in_op > 3'd4);
      end else w_in_valid = 1'b0;
      @(negedge clk);
      if (w_in_valid && w_in_ready !== 6'h3f) ready_bad = 1'b1;
      for (int s = 0; s < 6; s++) begin
        if (w_out_valid[s]) begin
          int k;
          k = w_idx[s];
          if (w_first[s] < 0) w_first[s] = cyc;
          checks++;
          if (k >= N) begin
            errors++;
            $display("FAIL wide_extra[S=%0d]: got result %0d expected only %0d", s + 1, k, N);
          end else if (w_out_data[s] !== exp_wd[k] || w_out_tag[s] !== 5'(k) || w_out_err[s] !== exp_we[k]) begin
            errors++;
            $display("FAIL wide_data[S=%0d,%0d]: got %h/%0d/%b expected %h/%0d/%b", s + 1, k,
                     w_out_data[s], w_out_tag[s], w_out_err[s], exp_wd[k], k, exp_we[k]);
          end
          w_idx[s]++;
        end
      end
      @(posedge clk);
      #1;
    end
    for (int s = 0; s < 6; s++) begin
      checks++;
      if (w_idx[s] != N || w_first[s] != s + 1) begin
        errors++;
        $display("FAIL wide_count[S=%0d]: got %0d results first at %0d expected %0d first at %0d",
                 s + 1, w_idx[s], w_first[s], N, s + 1);
      end
    end
    checks++;
    if (ready_bad) begin errors++; $display("FAIL wide_in_ready: got a drop expected always 1"); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_flush();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
